// File: rtl/write_back_if.sv
// MEM/WB bundle into the write-back stage plus the register-file write
// port and stall it drives back toward decode and the upstream pipeline.
interface write_back_if #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3
);
  logic              inValid;
  logic              inRegWrite;
  logic              inMemToReg;
  logic              inOutEn;
  logic              inSwap;
  logic [REG_AW-1:0] inRdst;
  logic [REG_AW-1:0] inRsec;
  logic [DATA_W-1:0] aluResult;
  logic [DATA_W-1:0] memData;
  logic [DATA_W-1:0] secData;

  logic              regWrite;
  logic [REG_AW-1:0] Rdst;
  logic [DATA_W-1:0] writeData;
  logic              stall;

  modport master (
    output inValid, inRegWrite, inMemToReg, inOutEn, inSwap,
    output inRdst, inRsec, aluResult, memData, secData,
    input  regWrite, Rdst, writeData, stall
  );

  modport slave (
    input  inValid, inRegWrite, inMemToReg, inOutEn, inSwap,
    input  inRdst, inRsec, aluResult, memData, secData,
    output regWrite, Rdst, writeData, stall
  );
endinterface

// File: rtl/write_back.sv
// Final pipeline stage: registers the register-file write, the output port and
// the retire counter, and splits SWAP into two writes over one write port.
module write_back #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  write_back_if.slave       bus,
  output logic [DATA_W-1:0] outPort,
  output logic [CNT_W-1:0]  retireCount
);

  typedef enum logic {IDLE, SWAP2} state_t;

  state_t            state, state_nx;
  logic [REG_AW-1:0] pend_dst, pend_dst_nx;
  logic [DATA_W-1:0] pend_data, pend_data_nx;
  logic              reg_write_nx;
  logic [REG_AW-1:0] rdst_nx;
  logic [DATA_W-1:0] write_data_nx;
  logic [DATA_W-1:0] out_port_nx;
  logic              stall_nx;
  logic [CNT_W-1:0]  retire_nx;
  logic [DATA_W-1:0] sel_data;

  assign sel_data = bus.inMemToReg ? bus.memData : bus.aluResult;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      pend_dst      <= '0;
      pend_data     <= '0;
      bus.regWrite  <= 1'b0;
      bus.Rdst      <= '0;
      bus.writeData <= '0;
      bus.stall     <= 1'b0;
      outPort       <= '0;
      retireCount   <= '0;
    end else begin
      state         <= state_nx;
      pend_dst      <= pend_dst_nx;
      pend_data     <= pend_data_nx;
      bus.regWrite  <= reg_write_nx;
      bus.Rdst      <= rdst_nx;
      bus.writeData <= write_data_nx;
      bus.stall     <= stall_nx;
      outPort       <= out_port_nx;
      retireCount   <= retire_nx;
    end
  end

  // SWAP retires only once its second write has been issued
  always_comb begin
    state_nx      = state;
    pend_dst_nx   = pend_dst;
    pend_data_nx  = pend_data;
    reg_write_nx  = 1'b0;
    rdst_nx       = bus.Rdst;
    write_data_nx = bus.writeData;
    out_port_nx   = outPort;
    stall_nx      = 1'b0;
    retire_nx     = retireCount;

    case (state)
      IDLE: begin
        if (bus.inValid) begin
          rdst_nx       = bus.inRdst;
          write_data_nx = sel_data;
          if (bus.inOutEn) out_port_nx = sel_data;
          if (bus.inSwap) begin
            reg_write_nx = 1'b1;
            pend_dst_nx  = bus.inRsec;
            pend_data_nx = bus.secData;
            stall_nx     = 1'b1;
            state_nx     = SWAP2;
          end else begin
            reg_write_nx = bus.inRegWrite;
            retire_nx    = retireCount + CNT_W'(1);
          end
        end
      end
      SWAP2: begin
        reg_write_nx  = 1'b1;
        rdst_nx       = pend_dst;
        write_data_nx = pend_data;
        retire_nx     = retireCount + CNT_W'(1);
        state_nx      = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_write_back.sv
// Self-checking bench for write_back: directed scenarios plus randomized
// traffic checked against a queue-based model of owed register writes.
module tb_write_back;
  localparam int DATA_W = 16;
  localparam int REG_AW = 3;
  localparam int CNT_W  = 16;

  logic clk = 1'b0;
  logic rst;
  logic rst4;
  logic [DATA_W-1:0] outPort;
  logic [CNT_W-1:0]  retireCount;
  logic [DATA_W-1:0] outPort4;
  logic [3:0]        retireCount4;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  write_back_if #(.DATA_W(DATA_W), .REG_AW(REG_AW)) bus ();
  write_back_if #(.DATA_W(DATA_W), .REG_AW(REG_AW)) bus4 ();

  write_back #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .bus(bus), .outPort(outPort), .retireCount(retireCount)
  );

  write_back #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst4), .bus(bus4), .outPort(outPort4), .retireCount(retireCount4)
  );

  typedef struct {
    logic [REG_AW-1:0] dst;
    logic [DATA_W-1:0] data;
  } wr_t;

  // Model: each instruction owes one or two writes; owed second writes wait in a queue
  wr_t               owed[$];
  logic              m_regWrite;
  logic [REG_AW-1:0] m_Rdst;
  logic [DATA_W-1:0] m_writeData;
  logic [DATA_W-1:0] m_outPort;
  logic              m_stall;
  logic [CNT_W-1:0]  m_retire;

  task automatic idle_inputs();
    bus.inValid = 0; bus.inRegWrite = 0; bus.inMemToReg = 0; bus.inOutEn = 0;
    bus.inSwap = 0; bus.inRdst = 0; bus.inRsec = 0;
    bus.aluResult = 0; bus.memData = 0; bus.secData = 0;
  endtask

  task automatic set_bundle(input logic rw, input logic m2r, input logic oe, input logic sw,
                            input logic [REG_AW-1:0] d, input logic [REG_AW-1:0] s,
                            input logic [DATA_W-1:0] alu, input logic [DATA_W-1:0] mem,
                            input logic [DATA_W-1:0] sec);
    bus.inValid = 1; bus.inRegWrite = rw; bus.inMemToReg = m2r; bus.inOutEn = oe;
    bus.inSwap = sw; bus.inRdst = d; bus.inRsec = s;
    bus.aluResult = alu; bus.memData = mem; bus.secData = sec;
  endtask

  task automatic tick();
    logic [DATA_W-1:0] sel;
    @(posedge clk);
    sel = bus.inMemToReg ? bus.memData : bus.aluResult;
    if (rst) begin
      owed.delete();
      m_regWrite = 0; m_Rdst = 0; m_writeData = 0; m_outPort = 0; m_stall = 0; m_retire = 0;
    end else if (owed.size() > 0) begin
      wr_t w;
      w = owed.pop_front();
      m_regWrite = 1; m_Rdst = w.dst; m_writeData = w.data; m_stall = 0;
      m_retire = m_retire + 1;
    end else begin
      m_regWrite = 0; m_stall = 0;
      if (bus.inValid) begin
        m_Rdst = bus.inRdst; m_writeData = sel;
        if (bus.inOutEn) m_outPort = sel;
        if (bus.inSwap) begin
          wr_t w;
          w.dst = bus.inRsec; w.data = bus.secData;
          owed.push_back(w);
          m_regWrite = 1; m_stall = 1;
        end else begin
          m_regWrite = bus.inRegWrite;
          m_retire = m_retire + 1;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    set_bundle(1, 0, 1, 1, 3'd6, 3'd7, 16'hAAAA, 16'h5555, 16'h1111);
    tick();
    rst = 0;
    idle_inputs();
    tests++;
    if (bus.regWrite !== 1'b0 || bus.Rdst !== '0 || bus.writeData !== '0 ||
        outPort !== '0 || bus.stall !== 1'b0 || retireCount !== '0) begin
      fails++;
      $display("[TB] FAIL reset: regWrite=%b Rdst=%0d writeData=%h outPort=%h stall=%b retire=%0d, expected all zero",
               bus.regWrite, bus.Rdst, bus.writeData, outPort, bus.stall, retireCount);
    end
  endtask

  task automatic test_alu_write();
    do_reset();
    set_bundle(1, 0, 0, 0, 3'd3, 3'd0, 16'h1234, 16'hFFFF, 16'h0);
    tick();
    idle_inputs();
    tests++;
    if (bus.regWrite !== 1'b1 || bus.Rdst !== 3'd3 || bus.writeData !== 16'h1234 || retireCount !== 16'd1) begin
      fails++;
      $display("[TB] FAIL alu_write: regWrite=%b Rdst=%0d writeData=%h retire=%0d, expected 1/3/1234/1",
               bus.regWrite, bus.Rdst, bus.writeData, retireCount);
    end
  endtask

  task automatic test_load_out();
    do_reset();
    set_bundle(1, 1, 0, 0, 3'd5, 3'd0, 16'h0000, 16'hBEEF, 16'h0);
    tick();
    tests++;
    if (bus.regWrite !== 1'b1 || bus.Rdst !== 3'd5 || bus.writeData !== 16'hBEEF) begin
      fails++;
      $display("[TB] FAIL load: regWrite=%b Rdst=%0d writeData=%h, expected 1/5/beef",
               bus.regWrite, bus.Rdst, bus.writeData);
    end
    set_bundle(0, 0, 1, 0, 3'd0, 3'd0, 16'h00A5, 16'h0000, 16'h0);
    tick();
    idle_inputs();
    tests++;
    if (bus.regWrite !== 1'b0 || outPort !== 16'h00A5 || retireCount !== 16'd2) begin
      fails++;
      $display("[TB] FAIL out: regWrite=%b outPort=%h retire=%0d, expected 0/00a5/2",
               bus.regWrite, outPort, retireCount);
    end
  endtask

  task automatic test_swap();
    do_reset();
    set_bundle(1, 0, 0, 1, 3'd1, 3'd2, 16'h0002, 16'h0000, 16'h0001);
    tick();
    tests++;
    if (bus.regWrite !== 1'b1 || bus.Rdst !== 3'd1 || bus.writeData !== 16'h0002 ||
        bus.stall !== 1'b1 || retireCount !== 16'd0) begin
      fails++;
      $display("[TB] FAIL swap_first: regWrite=%b Rdst=%0d writeData=%h stall=%b retire=%0d, expected 1/1/0002/1/0",
               bus.regWrite, bus.Rdst, bus.writeData, bus.stall, retireCount);
    end
    tick();
    idle_inputs();
    tests++;
    if (bus.regWrite !== 1'b1 || bus.Rdst !== 3'd2 || bus.writeData !== 16'h0001 ||
        bus.stall !== 1'b0 || retireCount !== 16'd1) begin
      fails++;
      $display("[TB] FAIL swap_second: regWrite=%b Rdst=%0d writeData=%h stall=%b retire=%0d, expected 1/2/0001/0/1",
               bus.regWrite, bus.Rdst, bus.writeData, bus.stall, retireCount);
    end
    tick();
    tests++;
    if (bus.regWrite !== 1'b0 || retireCount !== 16'd1) begin
      fails++;
      $display("[TB] FAIL swap_no_third: regWrite=%b retire=%0d, expected 0/1", bus.regWrite, retireCount);
    end
  endtask

  task automatic test_reset_mid_swap();
    do_reset();
    set_bundle(1, 0, 0, 1, 3'd1, 3'd2, 16'h0002, 16'h0000, 16'h0001);
    tick();
    rst = 1;
    tick();
    rst = 0;
    idle_inputs();
    tests++;
    if (bus.regWrite !== 1'b0 || bus.stall !== 1'b0 || retireCount !== '0) begin
      fails++;
      $display("[TB] FAIL reset_mid_swap: regWrite=%b stall=%b retire=%0d, expected 0/0/0",
               bus.regWrite, bus.stall, retireCount);
    end
    tick();
    tests++;
    if (bus.regWrite !== 1'b0) begin
      fails++;
      $display("[TB] FAIL swap_discarded: regWrite=%b Rdst=%0d, expected regWrite 0", bus.regWrite, bus.Rdst);
    end
    set_bundle(1, 0, 0, 0, 3'd4, 3'd0, 16'h0C0C, 16'h0000, 16'h0);
    tick();
    idle_inputs();
    tests++;
    if (bus.regWrite !== 1'b1 || bus.Rdst !== 3'd4 || bus.writeData !== 16'h0C0C || bus.stall !== 1'b0) begin
      fails++;
      $display("[TB] FAIL idle_after_reset: regWrite=%b Rdst=%0d writeData=%h stall=%b, expected 1/4/0c0c/0",
               bus.regWrite, bus.Rdst, bus.writeData, bus.stall);
    end
  endtask

  task automatic test_counter_wrap();
    rst4 = 1;
    tick();
    rst4 = 0;
    bus4.inValid = 1; bus4.inRegWrite = 1; bus4.inSwap = 0; bus4.inOutEn = 0;
    for (int i = 1; i <= 17; i++) begin
      bus4.inRdst = REG_AW'(i);
      bus4.aluResult = DATA_W'(i);
      tick();
      tests++;
      if (retireCount4 !== 4'(i % 16)) begin
        fails++;
        $display("[TB] FAIL counter_wrap[%0d]: retireCount=%0d, expected %0d", i, retireCount4, i % 16);
      end
    end
    bus4.inValid = 0;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 39) == 0);
      if (!m_stall) begin
        if ($urandom_range(0, 4) == 0) idle_inputs();
        else set_bundle(1'($urandom), 1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0),
                        REG_AW'($urandom), REG_AW'($urandom), DATA_W'($urandom),
                        DATA_W'($urandom), DATA_W'($urandom));
      end
      tick();
      tests++;
      if (bus.regWrite !== m_regWrite || bus.stall !== m_stall || outPort !== m_outPort ||
          retireCount !== m_retire ||
          (m_regWrite && (bus.Rdst !== m_Rdst || bus.writeData !== m_writeData))) begin
        fails++;
        $display("[TB] FAIL random[%0d]: got we=%b rd=%0d wd=%h out=%h st=%b cnt=%0d, expected we=%b rd=%0d wd=%h out=%h st=%b cnt=%0d",
                 c, bus.regWrite, bus.Rdst, bus.writeData, outPort, bus.stall, retireCount,
                 m_regWrite, m_Rdst, m_writeData, m_outPort, m_stall, m_retire);
      end
    end
    rst = 0;
    idle_inputs();
  endtask

  initial begin
    rst = 1;
    rst4 = 1;
    idle_inputs();
    bus4.inValid = 0; bus4.inRegWrite = 0; bus4.inMemToReg = 0; bus4.inOutEn = 0;
    bus4.inSwap = 0; bus4.inRdst = 0; bus4.inRsec = 0;
    bus4.aluResult = 0; bus4.memData = 0; bus4.secData = 0;
    @(negedge clk);
    test_reset();
    test_alu_write();
    test_load_out();
    test_swap();
    test_reset_mid_swap();
    test_counter_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/write_back.md
Name: write_back

Overview:
- Final pipeline stage. Consumes the MEM/WB pipeline bundle and drives the register-file write interface that the decode stage consumes: regWrite, Rdst and writeData.
- Also owns the output-port register and a retired-instruction counter.
- Sequences two-write instructions (SWAP) over the single register-file write port, stalling upstream for one cycle.

Parameters:
- DATA_W, 16, datapath and port width
- REG_AW, 3, register index width (8 registers)
- CNT_W, 16, retired-instruction counter width

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- inValid  input  1  MEM/WB bundle holds a real instruction this cycle
- inRegWrite  input  1  instruction writes a register
- inMemToReg  input  1  1 = write data from memData, 0 = from aluResult
- inOutEn  input  1  instruction writes the output port
- inSwap  input  1  instruction needs two register writes
- inRdst  input  REG_AW  first write destination
- inRsec  input  REG_AW  second write destination (SWAP only)
- aluResult  input  DATA_W  ALU result
- memData  input  DATA_W  memory read data
- secData  input  DATA_W  second write value (SWAP only)
- regWrite  output  1  register-file write enable, to decode
- Rdst  output  REG_AW  register-file write index, to decode
- writeData  output  DATA_W  register-file write data, to decode
- outPort  output  DATA_W  output-port register
- stall  output  1  upstream must hold the MEM/WB bundle
- retireCount  output  CNT_W  count of retired instructions

Behaviour:
- Reset: when rst=1 at a clock edge, all outputs go to 0 and the FSM goes to IDLE. Any pending second SWAP write is discarded. rst wins over every other input.
- All outputs are registered. An instruction accepted at edge N produces its write on regWrite/Rdst/writeData during cycle N+1. The register file commits the write at the end of N+1.
- selData = inMemToReg ? memData : aluResult.
- FSM has two states: IDLE and SWAP2.
- IDLE, inValid=0:
  - regWrite <= 0.
  - Rdst and writeData keep their values.
  - stall <= 0.
- IDLE, inValid=1, inSwap=0:
  - regWrite <= inRegWrite, Rdst <= inRdst, writeData <= selData.
  - If inOutEn=1: outPort <= selData.
  - retireCount <= retireCount+1.
  - Stay in IDLE.
- IDLE, inValid=1, inSwap=1:
  - regWrite <= 1, Rdst <= inRdst, writeData <= selData.
  - Latch pendDst <= inRsec, pendData <= secData.
  - stall <= 1; go to SWAP2.
  - retireCount is not incremented yet.
- SWAP2:
  - regWrite <= 1, Rdst <= pendDst, writeData <= pendData.
  - stall <= 0; go to IDLE.
  - retireCount <= retireCount+1.
  - All in* inputs are ignored in this state; upstream holds them because stall=1.
- Stall timing: stall is 1 during exactly one cycle, the cycle the first SWAP write is presented. The held bundle is accepted at the edge that ends the cycle in which stall=0 again.
- outPort holds its value unless written. inOutEn together with inSwap writes outPort with the first-write data only.
- retireCount wraps from 2^CNT_W−1 to 0 with no flag.
- If inRegWrite=0 and inOutEn=1, only outPort changes; regWrite=0.
- Back-to-back non-SWAP instructions retire one per cycle with no bubbles.
- SWAP with inRdst==inRsec: both writes are issued; the second write's value is the final register content.

Test Plan:
1. Reset: drive rst=1 with inValid=1 and any data -> next cycle regWrite=0, Rdst=0, writeData=0, outPort=0, stall=0, retireCount=0.
2. ALU write: inValid=1, inRegWrite=1, inMemToReg=0, inRdst=3, aluResult=0x1234, memData=0xFFFF -> next cycle regWrite=1, Rdst=3, writeData=0x1234; retireCount=1.
3. Load then OUT back-to-back:
   - Cycle A: inMemToReg=1, memData=0xBEEF, inRdst=5.
   - Cycle B: inRegWrite=0, inOutEn=1, aluResult=0x00A5.
   - Response: A+1 writes R5=0xBEEF; B+1 has regWrite=0 and outPort=0x00A5; retireCount=2.
4. SWAP: inSwap=1, inRdst=1, aluResult=0x0002, inRsec=2, secData=0x0001, bundle held while stall=1 ->
   - Cycle N+1: regWrite=1, Rdst=1, writeData=0x0002, stall=1.
   - Cycle N+2: Rdst=2, writeData=0x0001, stall=0.
   - retireCount increments once.
   - No third write occurs.
5. Reset mid-SWAP: assert rst during the stall=1 cycle -> next cycle regWrite=0, stall=0, FSM in IDLE; the second write (R2) never appears.
6. Counter wrap: set CNT_W=4 and retire 17 instructions -> retireCount reads 15 after the 15th, 0 after the 16th, 1 after the 17th.
